// File: rtl/calendar_pkg.sv
// Shared calendar definitions: field indices, field widths, button FSM
// states and the month-length / wrap helpers used by the editor datapath.
package calendar_pkg;

    localparam int STATE_W = 5;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 7;

    // Field selector codes driven on i_state.
    localparam logic [STATE_W-1:0] FLD_SEC   = 5'd0;
    localparam logic [STATE_W-1:0] FLD_MIN   = 5'd1;
    localparam logic [STATE_W-1:0] FLD_HOUR  = 5'd2;
    localparam logic [STATE_W-1:0] FLD_DAY   = 5'd3;
    localparam logic [STATE_W-1:0] FLD_MONTH = 5'd4;
    localparam logic [STATE_W-1:0] FLD_YEAR  = 5'd5;
    localparam logic [STATE_W-1:0] FLD_FMT   = 5'd6;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_HOLD,
        BTN_REPEAT
    } btn_state_e;

    // Days in a month; every year divisible by 4 is a leap year in 2000-2099.
    function automatic logic [DAY_W-1:0] month_len(input logic [MONTH_W-1:0] month,
                                                   input logic [YEAR_W-1:0]  year);
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    // One step up or down inside [lo, hi], wrapping at either end.
    function automatic logic [6:0] wrap_step(input logic [6:0] val,
                                             input logic [6:0] lo,
                                             input logic [6:0] hi,
                                             input logic       inc);
        if (inc) begin
            return (val >= hi) ? lo : val + 7'd1;
        end
        return (val <= lo) ? hi : val - 7'd1;
    endfunction

endpackage

// File: rtl/button_repeat.sv
// Push-button conditioner: 2-FF synchroniser followed by an IDLE/HOLD/REPEAT
// auto-repeat FSM. step_o is decoded from registered state only, so a clean
// button rise moves the edited field on the third clock edge.
module button_repeat
    import calendar_pkg::*;
#(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int CNT_W         = 10
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic step_o
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       sync_q;
    logic             synced;
    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    assign synced = sync_q[1];

    // Bring the asynchronous button into the clock domain.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Step pulse: first press, end of the hold delay, then every repeat period.
    // NOTE: step_o gets a default before the case so no latch is inferred.
    always_comb begin
        step_o = 1'b0;
        unique case (state_q)
            BTN_IDLE:   step_o = synced;
            BTN_HOLD:   step_o = synced && (cnt_q == DELAY_LAST);
            BTN_REPEAT: step_o = synced && (cnt_q == PERIOD_LAST);
            default:    step_o = 1'b0;
        endcase
    end

    // Auto-repeat FSM; a released button returns to IDLE from any state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
        end else if (!synced) begin
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                BTN_IDLE: begin
                    state_q <= BTN_HOLD;
                    cnt_q   <= '0;
                end
                BTN_HOLD: begin
                    if (cnt_q == DELAY_LAST) begin
                        state_q <= BTN_REPEAT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BTN_REPEAT: begin
                    cnt_q <= (cnt_q == PERIOD_LAST) ? '0 : cnt_q + 1'b1;
                end
                default: begin
                    state_q <= BTN_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/calendar_field_editor.sv
// Date/time register file of the calendar clock. Run mode counts seconds with
// a full carry chain into the date; edit mode freezes time and lets the up/down
// buttons step one selected field, wrapping without carry.
module calendar_field_editor
    import calendar_pkg::*;
#(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int CNT_W         = 10
) (
    input  logic               i_clk_0_001s,
    input  logic               reset,
    input  logic               i_tick_1s,
    input  logic               i_is_modify,
    input  logic [STATE_W-1:0] i_state,
    input  logic               up,
    input  logic               down,
    output logic [SEC_W-1:0]   o_second,
    output logic [MIN_W-1:0]   o_minute,
    output logic [HOUR_W-1:0]  o_hour,
    output logic [DAY_W-1:0]   o_day,
    output logic [MONTH_W-1:0] o_month,
    output logic [YEAR_W-1:0]  o_year,
    output logic               o_is_12h
);

    logic up_step;
    logic dn_step;
    logic step_any;
    logic step_inc;
    logic tick_run;

    logic [SEC_W-1:0]   sec_q,   sec_d;
    logic [MIN_W-1:0]   min_q,   min_d;
    logic [HOUR_W-1:0]  hour_q,  hour_d;
    logic [DAY_W-1:0]   day_q,   day_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [YEAR_W-1:0]  year_q,  year_d;
    logic               is12_q,  is12_d;
    logic               clamp_q, clamp_d;

    logic [DAY_W-1:0]   ml;
    logic [DAY_W-1:0]   day_base;

    button_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W        (CNT_W)
    ) u_up (
        .clk_i  (i_clk_0_001s),
        .rst_n_i(reset),
        .btn_i  (up),
        .step_o (up_step)
    );

    button_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W        (CNT_W)
    ) u_down (
        .clk_i  (i_clk_0_001s),
        .rst_n_i(reset),
        .btn_i  (down),
        .step_o (dn_step)
    );

    // Simultaneous up+down cancels; steps outside edit mode are dropped.
    assign step_any = (up_step ^ dn_step) & i_is_modify;
    assign step_inc = up_step;
    assign tick_run = i_tick_1s & ~i_is_modify;

    // Next-state of the field registers: clamp, run-mode carry chain, edit step.
    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        month_d = month_q;
        year_d  = year_q;
        is12_d  = is12_q;
        clamp_d = 1'b0;

        // Pending clamp after a month/year edit is folded into the day seen below.
        ml       = month_len(month_q, year_q);
        day_base = (clamp_q && (day_q > ml)) ? ml : day_q;
        day_d    = day_base;

        if (tick_run) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    if (hour_q == 5'd23) begin
                        hour_d = 5'd0;
                        if (day_base >= ml) begin
                            day_d = 5'd1;
                            if (month_q == 4'd12) begin
                                month_d = 4'd1;
                                year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                            end else begin
                                month_d = month_q + 4'd1;
                            end
                        end else begin
                            day_d = day_base + 5'd1;
                        end
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (step_any) begin
            case (i_state)
                FLD_SEC:   sec_d  = SEC_W'(wrap_step(7'(sec_q), 7'd0, 7'd59, step_inc));
                FLD_MIN:   min_d  = MIN_W'(wrap_step(7'(min_q), 7'd0, 7'd59, step_inc));
                FLD_HOUR:  hour_d = HOUR_W'(wrap_step(7'(hour_q), 7'd0, 7'd23, step_inc));
                FLD_DAY:   day_d  = DAY_W'(wrap_step(7'(day_base), 7'd1, 7'(ml), step_inc));
                FLD_MONTH: begin
                    month_d = MONTH_W'(wrap_step(7'(month_q), 7'd1, 7'd12, step_inc));
                    clamp_d = 1'b1;
                end
                FLD_YEAR: begin
                    year_d  = wrap_step(year_q, 7'd0, 7'd99, step_inc);
                    clamp_d = 1'b1;
                end
                FLD_FMT:   is12_d = ~is12_q;
                default:   ;
            endcase
        end
    end

    // Field registers; reset value is 2000-01-01 00:00:00 in 24 h format.
    always_ff @(posedge i_clk_0_001s or negedge reset) begin
        if (!reset) begin
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= 5'd1;
            month_q <= 4'd1;
            year_q  <= '0;
            is12_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            is12_q  <= is12_d;
            clamp_q <= clamp_d;
        end
    end

    assign o_second = sec_q;
    assign o_minute = min_q;
    assign o_hour   = hour_q;
    assign o_day    = day_q;
    assign o_month  = month_q;
    assign o_year   = year_q;
    assign o_is_12h = is12_q;

endmodule
